mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Round-robin arbiter that shares the single-port memory block between NUM_REQ independent requesters. Each requester port has its own valid/ready command handshake. The arbiter latches one winning command, drives the memory's valid/wr_rd/addr/wdata interface until the memory returns ready, captures read data, and returns a one-cycle ready pulse to the winner. It sits between client logic (DMA, CPU-side ports) and the memory instance.

Parameters:
WIDTH, 8, data width in bits; matches the memory.
DEPTH, 16, memory depth in words.
ADDR_WIDTH, $clog2(DEPTH), address width.
NUM_REQ, 4, number of requesters (2..8).
TIMEOUT_CYCLES, 15, watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
clk  input  1  single clock; all logic is on the posedge
rst  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  NUM_REQ  per-requester command valid; held until its req_ready pulse
req_wr_rd  input  NUM_REQ  per-requester direction: 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*WIDTH  flattened write data, packed the same way
req_ready  output  NUM_REQ  one-hot, one-cycle completion pulse
req_rdata  output  WIDTH  read data, shared; valid while req_ready pulses for a read
gnt  output  NUM_REQ  one-hot owner of the current transaction; 0 when idle
m_valid  output  1  to memory valid
m_wr_rd  output  1  to memory wr_rd
m_addr  output  ADDR_WIDTH  to memory addr
m_wdata  output  WIDTH  to memory wdata
m_rdata  input  WIDTH  from memory rdata
m_ready  input  1  from memory ready

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0: req_ready, req_rdata, gnt, m_valid, m_wr_rd, m_addr, m_wdata.
  - Reset mid-transaction aborts immediately: m_valid drops without waiting for the clock, and no req_ready is issued.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE, when any req_valid bit is set, at the clock edge:
  - Select the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap.
  - Latch that requester's wr_rd/addr/wdata into command registers.
  - Set gnt one-hot and go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE:
  - m_valid=1; m_wr_rd/m_addr/m_wdata come from the latched command and stay stable.
  - When m_ready=1 at an edge: capture m_rdata into req_rdata on a read; go to RESP with m_valid=0.
  - m_ready may be sampled high in the first ISSUE cycle.
- RESP:
  - req_ready[gnt]=1 for exactly one cycle.
  - At the next edge: last_grant=gnt index, gnt=0, go to IDLE.
- Minimum latency: req_valid sampled at edge N gives m_valid high in cycle N+1. With m_ready already high, req_ready is high in cycle N+2. Peak throughput is one transaction per 3 cycles.
- req_rdata holds its value until the next completed read; writes do not modify it.
- Changes to the winner's req_valid or fields after the grant edge are ignored; the latched command completes.
  - Deasserting valid before ready is a protocol violation, but the arbiter still completes and pulses ready.
- Requesters drop req_valid in the cycle after their req_ready. A valid still held in IDLE is re-arbitrated as a new request.
- Fairness: a requester waits at most NUM_REQ-1 transactions while continuously valid.
- m_ready observed in IDLE or RESP is ignored.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - Adds output port req_err (1 bit) and a cycle counter that clears on entering ISSUE.
  - If m_ready has not been sampled after TIMEOUT_CYCLES cycles in ISSUE: drop m_valid and go to RESP.
  - In that RESP cycle req_err=1 alongside the req_ready pulse, and req_rdata is unchanged.
  - req_err is 0 at reset and in all other cycles.
- Undefined: the req_err port and counter do not exist, and ISSUE waits indefinitely for m_ready.

Test Plan:
- Single write: rst released; req 1 writes addr=10, wdata=100 with memory ready → m_valid high with m_addr=10, m_wdata=100, m_wr_rd=1; req_ready=4'b0010 pulses once.
- Readback: req 2 reads addr=10 after the write → req_rdata=100 while req_ready[2]=1; gnt=4'b0100 during the transaction.
- Round-robin: all 4 requesters valid continuously after reset → grant order 0,1,2,3,0; no requester is granted twice before the others are served.
- Stall: m_ready held low 5 cycles in ISSUE → m_valid stays 1 and the command stays stable for all 5 cycles; completion follows on the first m_ready=1.
- Async reset mid-ISSUE: rst=0 between edges → m_valid, gnt and req_ready are 0 immediately. After release, the pending requester 0 is granted first.
- MEM_TIMEOUT_EN: m_ready never asserts → after 15 ISSUE cycles, req_ready and req_err pulse together and m_valid=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that shares one single-port memory between NUM_REQ
// requesters. One winning command is latched, driven to the memory until it
// answers with m_ready, and completed with a one-cycle req_ready pulse to
// the winner. Read data is captured into req_rdata and held until the next
// completed read.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Adds the req_err output and an ISSUE watchdog. If the memory has not
//   answered after TIMEOUT_CYCLES cycles, the transaction is abandoned and
//   completed with req_err=1 alongside req_ready.
//
// Ports:
//   clk        single clock, posedge
//   rst        asynchronous active-low reset
//   req_valid  per-requester command valid, held until its req_ready pulse
//   req_wr_rd  per-requester direction (1=write, 0=read)
//   req_addr   flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  flattened write data, requester i at [i*WIDTH +: WIDTH]
//   req_ready  one-hot one-cycle completion pulse
//   req_rdata  shared read data, valid while req_ready pulses for a read
//   gnt        one-hot owner of the current transaction, 0 when idle
//   req_err    (MEM_TIMEOUT_EN only) watchdog expiry flag, with req_ready
//   m_valid, m_wr_rd, m_addr, m_wdata   command to the memory
//   m_rdata, m_ready                    response from the memory
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH          = 8,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = $clog2(DEPTH),
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [WIDTH-1:0]              req_rdata,
    output logic [NUM_REQ-1:0]            gnt,
`ifdef MEM_TIMEOUT_EN
    output logic                          req_err,
`endif
    output logic                          m_valid,
    output logic                          m_wr_rd,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [WIDTH-1:0]              m_wdata,
    input  logic [WIDTH-1:0]              m_rdata,
    input  logic                          m_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Reject configurations the round-robin scan and watchdog are not built for.
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   owner;       // index form of gnt, becomes last_grant

    logic [IDX_W-1:0]   pick;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_found;
    logic [IDX_W-1:0]   cand;

`ifdef MEM_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer;
`endif

    // Round-robin pick: scan from last_grant+1 upward with wrap; the first
    // valid requester found wins.
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        pick       = '0;
        pick_oh    = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick          = cand;
                pick_oh[cand] = 1'b1;
                pick_found    = 1'b1;
            end
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // Asynchronous: m_valid, gnt and req_ready drop immediately,
            // aborting any transaction in flight.
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner      <= '0;
            gnt        <= '0;
            req_ready  <= '0;
            req_rdata  <= '0;
            m_valid    <= 1'b0;
            m_wr_rd    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
`ifdef MEM_TIMEOUT_EN
            req_err    <= 1'b0;
            timer      <= '0;
`endif
        end else begin
            // Completion flags are pulses; they are raised only on the
            // ISSUE->RESP edge below.
            req_ready <= '0;
`ifdef MEM_TIMEOUT_EN
            req_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        // Command is latched here; later changes on the
                        // requester's inputs do not affect this transaction.
                        owner   <= pick;
                        gnt     <= pick_oh;
                        m_valid <= 1'b1;
                        m_wr_rd <= req_wr_rd[pick];
                        m_addr  <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        m_wdata <= req_wdata[pick*WIDTH +: WIDTH];
`ifdef MEM_TIMEOUT_EN
                        timer   <= '0;
`endif
                        state   <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (m_ready) begin
                        if (!m_wr_rd) begin
                            req_rdata <= m_rdata;
                        end
                        m_valid   <= 1'b0;
                        req_ready <= gnt;
                        state     <= RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    // timer counts completed ISSUE cycles without m_ready;
                    // this edge closes cycle number timer+1.
                    else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        m_valid   <= 1'b0;
                        req_ready <= gnt;
                        req_err   <= 1'b1;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                RESP: begin
                    last_grant <= owner;
                    gnt        <= '0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
